// File: rtl/qsort_range_ctrl.sv
// rtl/qsort_range_ctrl.sv - quicksort range-stack sequencer driving an external partition engine
// Optional statistics outputs (part_count, max_depth) are enabled by defining QSORT_STATS_EN.
module qsort_range_ctrl #(
  parameter int IDX_W     = 8,
  parameter int STK_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] size,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             part_start,
  output logic [IDX_W-1:0] part_lo,
  output logic [IDX_W-1:0] part_hi,
  input  logic             part_done,
  input  logic [IDX_W-1:0] part_pivot
`ifdef QSORT_STATS_EN
  ,
  output logic [15:0]                      part_count,
  output logic [$clog2(STK_DEPTH+1)-1:0]   max_depth
`endif
);

  localparam int SP_W = $clog2(STK_DEPTH + 1);
  localparam int IW   = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SEED, S_POP, S_LAUNCH, S_WAIT, S_CHECK, S_PUSHA, S_PUSHB, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  size_q, size_d;
  logic [IDX_W-1:0]  lo_q, lo_d, hi_q, hi_d, piv_q, piv_d;
  logic              err_q, err_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IDX_W-1:0]  stk_lo_q [STK_DEPTH];
  logic [IDX_W-1:0]  stk_hi_q [STK_DEPTH];
  logic [15:0]       cnt_q, cnt_d;
  logic [SP_W-1:0]   maxd_q, maxd_d;

  logic              want_push, push_en;
  logic [IDX_W-1:0]  want_lo, want_hi;
  state_t            push_nxt;

  // Widened copies so p-1 / p+1 / lo+2 never wrap.
  logic [IDX_W:0]    lo_w, hi_w, p_w, left_len, right_len;
  logic              left_ok, right_ok, left_first;

  always_comb begin
    lo_w       = {1'b0, lo_q};
    hi_w       = {1'b0, hi_q};
    p_w        = {1'b0, piv_q};
    left_ok    = p_w >= lo_w + (IDX_W+1)'(2);
    right_ok   = p_w + (IDX_W+1)'(2) <= hi_w;
    left_len   = p_w - lo_w;
    right_len  = hi_w - p_w;
    left_first = left_ok && (!right_ok || left_len >= right_len);
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    piv_d     = piv_q;
    err_d     = err_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    maxd_d    = maxd_q;
    want_push = 1'b0;
    want_lo   = '0;
    want_hi   = '0;
    push_nxt  = S_POP;
    push_en   = 1'b0;

    case (state_q)
      S_IDLE: if (start) begin
        size_d  = size;
        err_d   = 1'b0;
        cnt_d   = '0;
        maxd_d  = '0;
        state_d = S_SEED;
      end
      S_SEED: begin
        if (size_q < IDX_W'(2)) state_d = S_DONE;
        else begin
          want_push = 1'b1;
          want_hi   = size_q - IDX_W'(1);
          push_nxt  = S_POP;
        end
      end
      S_POP: begin
        if (sp_q == '0) state_d = S_DONE;
        else begin
          sp_d    = sp_q - SP_W'(1);
          lo_d    = stk_lo_q[IW'(sp_q - SP_W'(1))];
          hi_d    = stk_hi_q[IW'(sp_q - SP_W'(1))];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        state_d = S_WAIT;
      end
      S_WAIT: if (part_done) begin
        piv_d   = part_pivot;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (piv_q < lo_q || piv_q > hi_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else state_d = S_PUSHA;
      end
      S_PUSHA: begin
        push_nxt = S_PUSHB;
        state_d  = S_PUSHB;
        if (left_first) begin
          want_push = 1'b1;
          want_lo   = lo_q;
          want_hi   = piv_q - IDX_W'(1);
        end else if (right_ok) begin
          want_push = 1'b1;
          want_lo   = piv_q + IDX_W'(1);
          want_hi   = hi_q;
        end
      end
      S_PUSHB: begin
        push_nxt = S_POP;
        state_d  = S_POP;
        if (left_first ? right_ok : left_ok) begin
          want_push = 1'b1;
          want_lo   = left_first ? piv_q + IDX_W'(1) : lo_q;
          want_hi   = left_first ? hi_q : piv_q - IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Overflow aborts the sort rather than dropping a range silently.
    if (want_push) begin
      if (sp_q == SP_W'(STK_DEPTH)) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_W'(1);
        state_d = push_nxt;
        if (sp_q + SP_W'(1) > maxd_q) maxd_d = sp_q + SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      piv_q   <= '0;
      err_q   <= 1'b0;
      sp_q    <= '0;
      cnt_q   <= '0;
      maxd_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      piv_q   <= piv_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      maxd_q  <= maxd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      stk_lo_q[IW'(sp_q)] <= want_lo;
      stk_hi_q[IW'(sp_q)] <= want_hi;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign part_start = (state_q == S_LAUNCH);
  assign error      = err_q;
  assign part_lo    = lo_q;
  assign part_hi    = hi_q;

`ifdef QSORT_STATS_EN
  assign part_count = cnt_q;
  assign max_depth  = maxd_q;
`endif

endmodule
